// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- raster timing source for the VGA display path.
//
// Divides the system clock into a pixel tick and walks a horizontal/vertical
// counter pair over the full raster (visible area plus porches and sync).
// Position, video_on and the sync strobes are all aligned to the same tick,
// so a consumer sampling on o_p_tick sees a consistent picture element.
//
// Ports:
//   i_clk          system clock (single domain)
//   i_reset        synchronous reset, active low
//   o_p_tick       one-clock pulse every TICK_DIV clocks
//   o_pixel_x      horizontal count, 0..H_TOTAL-1
//   o_pixel_y      vertical count, 0..V_TOTAL-1
//   o_video_on     high inside the visible window
//   o_hsync        active-low horizontal sync (registered)
//   o_vsync        active-low vertical sync (registered)
//   o_frame_start  one-clock pulse after the raster returns to (0,0)
//   o_frame_cnt    frames completed, modulo 64
//   o_blink        o_frame_cnt[5], toggles every 32 frames
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_p_tick,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_video_on,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start,
  output logic [5:0] o_frame_cnt,
  output logic       o_blink
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(TICK_DIV);

  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_start;
  logic [5:0]    r_frame_cnt;

  logic       w_tick;
  logic       w_h_end;
  logic       w_v_end;
  logic       w_frame_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  assign w_tick       = (r_div == DIV_MAX);
  assign w_h_end      = (r_h == H_MAX);
  assign w_v_end      = (r_v == V_MAX);
  assign w_frame_wrap = w_h_end && w_v_end;

  // Next-count values feed both the counters and the sync registers, which
  // keeps hsync/vsync aligned with the position they describe.
  assign w_h_nxt = w_h_end ? 10'd0 : r_h + 10'd1;
  assign w_v_nxt = !w_h_end ? r_v : (w_v_end ? 10'd0 : r_v + 10'd1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + DW'(1);
      r_frame_start <= w_tick && w_frame_wrap;
      if (w_tick) begin
        r_h     <= w_h_nxt;
        r_v     <= w_v_nxt;
        r_hsync <= !((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END));
        r_vsync <= !((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END));
        if (w_frame_wrap) r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  assign o_p_tick      = w_tick;
  assign o_pixel_x     = r_h;
  assign o_pixel_y     = r_v;
  assign o_video_on    = (r_h < H_VIS) && (r_v < V_VIS);
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_blink       = r_frame_cnt[5];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Three instances share one clock:
//   a: default 640x480 timing, TICK_DIV 4 -- reset, tick spacing, one line.
//   v: 12-tick lines with full 525-line vertical timing, TICK_DIV 2 --
//      vsync/video_on over a whole frame and a reset inside the sync window.
//   f: 12x7 raster, TICK_DIV 4 -- 64 frames for the frame counter wrap.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_v = 1'b0, rst_f = 1'b0;

  logic       pt_a, vo_a, hs_a, vs_a, fs_a, bl_a;
  logic [9:0] px_a, py_a;
  logic [5:0] fc_a;
  logic       pt_v, vo_v, hs_v, vs_v, fs_v, bl_v;
  logic [9:0] px_v, py_v;
  logic [5:0] fc_v;
  logic       pt_f, vo_f, hs_f, vs_f, fs_f, bl_f;
  logic [9:0] px_f, py_f;
  logic [5:0] fc_f;

  vga_sync_gen u_a (
    .i_clk(clk), .i_reset(rst_a), .o_p_tick(pt_a), .o_pixel_x(px_a),
    .o_pixel_y(py_a), .o_video_on(vo_a), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_frame_start(fs_a), .o_frame_cnt(fc_a), .o_blink(bl_a));

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                 .TICK_DIV(2)) u_v (
    .i_clk(clk), .i_reset(rst_v), .o_p_tick(pt_v), .o_pixel_x(px_v),
    .o_pixel_y(py_v), .o_video_on(vo_v), .o_hsync(hs_v), .o_vsync(vs_v),
    .o_frame_start(fs_v), .o_frame_cnt(fc_v), .o_blink(bl_v));

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                 .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                 .TICK_DIV(4)) u_f (
    .i_clk(clk), .i_reset(rst_f), .o_p_tick(pt_f), .o_pixel_x(px_f),
    .o_pixel_y(py_f), .o_video_on(vo_f), .o_hsync(hs_f), .o_vsync(vs_f),
    .o_frame_start(fs_f), .o_frame_cnt(fc_f), .o_blink(bl_f));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; samples are taken on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n, prev, lastpx, seqerr, vfall, hfall, hrise, hlow;
  logic prev_vo, prev_hs, prev_bl, found, wrapped;
  int vlow, vbad, vobad, fs_n, fs_clks, fs_xy_bad, moderr, toggles;
  logic [5:0] prev_fc, exp_fc;

  initial begin
    // ---------------- instance a: reset, tick, line ----------------
    step(2);
    rst_a = 1'b1;
    step(100);
    check("run_px_before_reset", px_a, 25);

    rst_a = 1'b0;
    step(3);
    check("rst_px", px_a, 0);
    check("rst_py", py_a, 0);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_frame_cnt", fc_a, 0);
    check("rst_p_tick", pt_a, 0);
    check("rst_frame_start", fs_a, 0);
    check("rst_video_on", vo_a, 1);
    check("rst_blink", bl_a, 0);

    rst_a = 1'b1;
    step(2);
    check("no_tick_early", pt_a, 0);
    step(1);
    check("first_tick", pt_a, 1);
    check("first_tick_px", px_a, 0);

    n = 0;
    do begin step(1); n++; end while (!pt_a && n < 20);
    check("tick_spacing", n, 4);
    check("second_tick_px", px_a, 1);

    prev = 1; lastpx = -1; seqerr = 0;
    vfall = -1; hfall = -1; hrise = -1; hlow = 0;
    prev_vo = vo_a; prev_hs = hs_a;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (pt_a) begin
        if (px_a == 10'd0) begin lastpx = prev; break; end
        if (int'(px_a) != prev + 1) seqerr++;
        if (prev_vo && !vo_a) vfall = px_a;
        if (prev_hs && !hs_a) hfall = px_a;
        if (!prev_hs && hs_a) hrise = px_a;
        if (!hs_a) hlow++;
        prev = px_a; prev_vo = vo_a; prev_hs = hs_a;
      end
    end
    check("line_px_sequence_errs", seqerr, 0);
    check("line_last_px", lastpx, 799);
    check("line_wrap_py", py_a, 1);
    check("line_wrap_video_on", vo_a, 1);
    check("video_on_fall_px", vfall, 640);
    check("hsync_fall_px", hfall, 656);
    check("hsync_rise_px", hrise, 752);
    check("hsync_low_ticks", hlow, 96);
    check("line_vsync", vs_a, 1);

    // ---------------- instance v: reset inside sync window ----------------
    rst_v = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      step(1);
      if (px_v == 10'd9 && py_v == 10'd490) begin found = 1'b1; break; end
    end
    check("midrst_reached", found, 1);
    check("midrst_pre_hsync", hs_v, 0);
    check("midrst_pre_vsync", vs_v, 0);
    rst_v = 1'b0;
    step(1);
    check("midrst_hsync", hs_v, 1);
    check("midrst_vsync", vs_v, 1);
    check("midrst_px", px_v, 0);
    check("midrst_py", py_v, 0);
    check("midrst_frame_start", fs_v, 0);
    check("midrst_frame_cnt", fc_v, 0);

    // ---------------- instance v: one full frame ----------------
    rst_v = 1'b1;
    vlow = 0; vbad = 0; vobad = 0; fs_n = 0; fs_clks = 0; fs_xy_bad = 0;
    for (int i = 0; i < 14000; i++) begin
      step(1);
      if (pt_v) begin
        if (!vs_v) begin
          vlow++;
          if (py_v != 10'd490 && py_v != 10'd491) vbad++;
        end
        if (py_v >= 10'd480 && vo_v) vobad++;
      end
      if (fs_v) begin
        fs_clks++;
        if (fs_n == 0) begin
          fs_n = 1;
          if (px_v != 10'd0 || py_v != 10'd0) fs_xy_bad++;
          check("frame1_cnt_at_start", fc_v, 1);
        end
      end else if (fs_n != 0) begin
        break;
      end
    end
    check("frame_start_seen", fs_n, 1);
    check("frame_start_width", fs_clks, 1);
    check("frame_start_at_origin_errs", fs_xy_bad, 0);
    check("vsync_low_ticks", vlow, 24);
    check("vsync_outside_window", vbad, 0);
    check("video_on_below_480", vobad, 0);
    check("frame1_cnt", fc_v, 1);
    check("frame1_blink", bl_v, 0);

    // ---------------- instance f: 64 frames ----------------
    rst_f = 1'b1;
    fs_n = 0; moderr = 0; toggles = 0; wrapped = 1'b0;
    prev_bl = bl_f; prev_fc = fc_f;
    for (int i = 0; i < 23000 && fs_n < 64; i++) begin
      step(1);
      if (fs_f) begin
        fs_n++;
        exp_fc = 6'(fs_n);
        if (fc_f !== exp_fc) moderr++;
        if (bl_f !== exp_fc[5]) moderr++;
        if (prev_fc == 6'd63 && fc_f == 6'd0) wrapped = 1'b1;
        prev_fc = fc_f;
      end
      if (bl_f != prev_bl) toggles++;
      prev_bl = bl_f;
    end
    check("wrap_frame_starts", fs_n, 64);
    check("wrap_cnt_model_errs", moderr, 0);
    check("wrap_63_to_0", wrapped, 1);
    check("wrap_blink_toggles", toggles, 2);
    check("wrap_final_cnt", fc_f, 0);
    check("wrap_final_blink", bl_f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
